// File: rtl/pipe_adder.sv
// Segmented pipelined adder: one SEG-bit slice per stage, global stall, registered outputs.
// Optional subtract mode (a + ~b + 1) is enabled by defining PIPE_ADDER_SUB_EN.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / SEG;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  // Signed overflow: equal operand signs, result sign differs.
  function automatic logic ovf_chk(input logic am, input logic bm, input logic sm);
    return (am == bm) && (sm != am);
  endfunction

  logic             sub_i;
  logic             adv;

  logic [STAGES:0]  vld_p;
  logic [STAGES:0]  cy_p;
  logic [WIDTH-1:0] opa_p [0:STAGES-1];
  logic [WIDTH-1:0] opb_p [0:STAGES-1];
  logic [WIDTH-1:0] acc_p [1:STAGES];
  logic             ovf_p;

  logic [SEG:0]     seg_r  [0:STAGES-1];
  logic [WIDTH-1:0] acc_nx [0:STAGES-1];

`ifdef PIPE_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  assign adv      = !vld_p[STAGES] || out_ready;
  assign in_ready = adv;

  always_comb begin
    acc_nx[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      acc_nx[k] = acc_p[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_r[k] = seg_add(opa_p[k][k*SEG +: SEG], opb_p[k][k*SEG +: SEG], cy_p[k]);
      acc_nx[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      // p0: capture operands; subtraction folds into inverted B with forced carry-in
      opa_p[0] <= a;
      opb_p[0] <= b ^ {WIDTH{sub_i}};
      cy_p[0]  <= c | sub_i;
      for (int k = 1; k < STAGES; k++) begin
        opa_p[k] <= opa_p[k-1];
        opb_p[k] <= opb_p[k-1];
      end
      // p1..pSTAGES: stage k adds slice k-1 and forwards its carry
      for (int k = 0; k < STAGES; k++) begin
        acc_p[k+1] <= acc_nx[k];
        cy_p[k+1]  <= seg_r[k][SEG];
      end
      ovf_p <= ovf_chk(opa_p[STAGES-1][WIDTH-1], opb_p[STAGES-1][WIDTH-1],
                       seg_r[STAGES-1][SEG-1]);
      vld_p <= {vld_p[STAGES-1:0], in_valid};
    end
    if (rst) begin
      vld_p         <= '0;
      acc_p[STAGES] <= '0;
      cy_p[STAGES]  <= 1'b0;
      ovf_p         <= 1'b0;
    end
  end

  assign sum       = acc_p[STAGES];
  assign carry     = cy_p[STAGES];
  assign overflow  = ovf_p;
  assign out_valid = vld_p[STAGES];

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: age-based queue model plus directed literal cases.
module tb_pipe_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, c, in_valid, in_ready, carry, overflow, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
`ifdef PIPE_ADDER_SUB_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .SEG(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
`ifdef PIPE_ADDER_SUB_EN
    .sub(sub),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .carry(carry),
    .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           rem;
  } ent_t;

  ent_t q[$];

  // Reference arithmetic on plain integers
  function automatic ent_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
    ent_t e;
    longint ux, uy, sx, sy, ures, sres;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      ures = ux - uy;
      sres = sx - sy;
      e.co = (ux >= uy);
    end else begin
      ures = ux + uy + longint'(ci);
      sres = sx + sy + longint'(ci);
      e.co = (ures >= 65536);
    end
    e.s   = W'(ures);
    e.ov  = (sres > 32767) || (sres < -32768);
    e.rem = 4;
    return e;
  endfunction

  logic started  = 1'b0;
  logic rst_prev = 1'b0;
  int   run      = 0;
  int   max_run  = 0;

  always @(negedge clk) begin
    logic ev, adv, sb;
    ev = (q.size() > 0) && (q[0].rem == 0);
    if (started) begin
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !ev || out_ready);
      if (ev) begin
        chk("sum", sum, q[0].s);
        chk("carry", carry, q[0].co);
        chk("overflow", overflow, q[0].ov);
      end else if (rst_prev) begin
        chk("reset sum", sum, 0);
        chk("reset carry", carry, 0);
        chk("reset overflow", overflow, 0);
      end
    end
    run = out_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
`ifdef PIPE_ADDER_SUB_EN
    sb = sub;
`else
    sb = 1'b0;
`endif
    adv      = !ev || out_ready;
    rst_prev = rst;
    if (rst) begin
      q.delete();
      started = 1'b1;
    end else if (adv) begin
      if (ev) void'(q.pop_front());
      foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
      if (in_valid) q.push_back(ref_op(a, b, c, sb));
    end
  end

  task automatic single(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input string nm);
    @(posedge clk); #1;
    a = x; b = y; c = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({nm, " early valid"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " valid"}, out_valid, 1);
    chk({nm, " sum"}, sum, es);
    chk({nm, " carry"}, carry, ec);
    chk({nm, " overflow"}, overflow, eo);
  endtask

  task automatic drive_rand(input logic v);
    a = W'($urandom);
    b = W'($urandom);
    c = 1'($urandom_range(0, 1));
    in_valid = v;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111; c = 1'b1; out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);
    chk("post-reset out_valid", out_valid, 0);
    chk("post-reset sum", sum, 0);

    single(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ffff+1");
    single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "7fff+1");
    single(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, "8000+8000+1");

    // Back-to-back stream
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive_rand(1'b1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("stream consecutive valid", max_run, 8);

    // Stream with output stalled for 6 cycles
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive_rand((i < 4) || ($urandom_range(0, 3) != 0));
      out_ready = !(i >= 4 && i < 10);
      if (i == 8) begin
        @(negedge clk);
        chk("stall in_ready", in_ready, 0);
        chk("stall out_valid", out_valid, 1);
      end
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drained queue", q.size(), 0);
    chk("drained out_valid", out_valid, 0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_rand(1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive_rand(1'b1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flushed out_valid", out_valid, 0);
    end
    single(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "after reset");

`ifdef PIPE_ADDER_SUB_EN
    sub = 1'b1;
    single(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "5-7");
    single(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, "8000-1");
    sub = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
